latch_bank_sync: RTL

- Parametrised, fully synchronous successor to the single-bit negative-level latch-with-reset primitive.
- Provides CHANNELS independent WIDTH-bit latch channels on one clock.
- Each channel has a selectable gate polarity, a per-channel gate glitch filter (counter-based FSM), a global freeze input and a capture-done pulse.
- Used in fabric primitive models and internal wrappers where latch semantics are needed without real level-sensitive storage.

---
 rtl/latch_bank_pkg.sv | 19 +
 rtl/latch_bank_chan.sv | 81 ++++++++
 rtl/latch_bank_sync.sv | 45 ++++
 3 files changed

// File: rtl/latch_bank_pkg.sv
// Shared types and helpers for the synchronous latch bank.
//   chan_state_t : per-channel filter state (HOLD = closed, OPEN = transparent)
//   cnt_width()  : width of the gate-filter counter for a given filter length
package latch_bank_pkg;

  typedef enum logic {
    HOLD = 1'b0,
    OPEN = 1'b1
  } chan_state_t;

  // The counter has to hold 0..filter, and is never narrower than one bit.
  function automatic int cnt_width(input int filter);
    int w;
    w = $clog2(filter + 1);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/latch_bank_chan.sv
// One latch channel: gate decode, counter-based glitch filter FSM, data
// register and capture-done pulse.
//   clk      : rising-edge clock
//   rst_n    : synchronous active-low reset
//   lock     : freeze all state when high
//   g        : raw gate input (polarity from GATE_ACTIVE_LOW)
//   d        : channel data in
//   q        : registered latch output
//   is_open  : 1 while the channel is transparent
//   captured : one-cycle pulse after the channel closes
module latch_bank_chan
  import latch_bank_pkg::*;
#(
  parameter int               WIDTH           = 8,
  parameter bit               GATE_ACTIVE_LOW = 1'b1,
  parameter int               FILTER_CYCLES   = 3,
  parameter logic [WIDTH-1:0] RESET_VALUE     = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lock,
  input  logic             g,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             is_open,
  output logic             captured
);

  localparam int            CW       = cnt_width(FILTER_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

  chan_state_t      state, state_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic [WIDTH-1:0] q_next;
  logic             captured_next;
  logic             ga;
  logic             mismatch;

  assign ga       = GATE_ACTIVE_LOW ? ~g : g;
  // Gate requests the opposite of the current state.
  assign mismatch = (state == HOLD) ? ga : ~ga;

  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    q_next        = q;
    captured_next = 1'b0;
    if (!lock) begin
      if (!mismatch) begin
        cnt_next = '0;
      end else if (cnt == CNT_LAST) begin
        state_next = (state == HOLD) ? OPEN : HOLD;
        cnt_next   = '0;
      end else begin
        cnt_next = cnt + 1'b1;
      end
      // Loading follows the pre-edge state: the closing edge still samples,
      // the opening edge does not.
      if (state == OPEN) q_next = d;
      captured_next = (state == OPEN) && (state_next == HOLD);
    end
  end

  // Register stage: state, filter counter, data and capture pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= HOLD;
      cnt      <= '0;
      q        <= RESET_VALUE;
      captured <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      q        <= q_next;
      captured <= captured_next;
    end
  end

  assign is_open = (state == OPEN);

endmodule

// File: rtl/latch_bank_sync.sv
// Bank of CHANNELS independent, fully synchronous latch channels.
//   C        : rising-edge clock
//   R        : synchronous active-low reset
//   D        : packed data, channel i at [i*WIDTH +: WIDTH]
//   G        : per-channel gate
//   LOCK     : global freeze, active-high
//   Q        : packed registered outputs, same packing as D
//   OPEN     : per-channel transparent flag
//   CAPTURED : per-channel one-cycle close pulse
module latch_bank_sync #(
  parameter int               WIDTH           = 8,
  parameter int               CHANNELS        = 4,
  parameter bit               GATE_ACTIVE_LOW = 1'b1,
  parameter int               FILTER_CYCLES   = 3,
  parameter logic [WIDTH-1:0] RESET_VALUE     = {WIDTH{1'b0}}
) (
  input  logic                      C,
  input  logic                      R,
  input  logic [CHANNELS*WIDTH-1:0] D,
  input  logic [CHANNELS-1:0]       G,
  input  logic                      LOCK,
  output logic [CHANNELS*WIDTH-1:0] Q,
  output logic [CHANNELS-1:0]       OPEN,
  output logic [CHANNELS-1:0]       CAPTURED
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    latch_bank_chan #(
      .WIDTH          (WIDTH),
      .GATE_ACTIVE_LOW(GATE_ACTIVE_LOW),
      .FILTER_CYCLES  (FILTER_CYCLES),
      .RESET_VALUE    (RESET_VALUE)
    ) u_chan (
      .clk     (C),
      .rst_n   (R),
      .lock    (LOCK),
      .g       (G[i]),
      .d       (D[i*WIDTH +: WIDTH]),
      .q       (Q[i*WIDTH +: WIDTH]),
      .is_open (OPEN[i]),
      .captured(CAPTURED[i])
    );
  end

endmodule
